seq_mult8_ctrl: RTL

SEQ_MULT8_CTRL -- requirements
Module: seq_mult8_ctrl

---
 rtl/seq_mult8_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/seq_mult8_ctrl.sv
// seq_mult8_ctrl: 8x8 unsigned shift-add multiplier built around one shared ripple-carry adder.
// Define SEQ_MULT8_SKIP_ZERO_EN to finish early once the remaining multiplier bits are all zero.
module rca8 (
  input  logic [7:0] i1,
  input  logic [7:0] i2,
  output logic [7:0] Sum,
  output logic       Carry
);
  logic [8:0] c;
  assign c[0] = 1'b0;
  for (genvar k = 0; k < 8; k++) begin : g_fa
    assign Sum[k]   = i1[k] ^ i2[k] ^ c[k];
    assign c[k+1]   = (i1[k] & i2[k]) | (c[k] & (i1[k] ^ i2[k]));
  end
  assign Carry = c[8];
endmodule

module seq_mult8_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  i1,
  input  logic [7:0]  i2,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [7:0]  mcand_q, hi_q, lo_q;
  logic [2:0]  cnt_q;
  logic        busy_q, done_q;
  logic [15:0] product_q;
  logic [7:0]  sum;
  logic        carry;
  logic [15:0] acc_d, fin_d;
  logic        last_d;
  rca8 u_add (.i1(hi_q), .i2(mcand_q), .Sum(sum), .Carry(carry));
  always_comb begin
    acc_d = lo_q[0] ? {carry, sum, lo_q[7:1]} : {1'b0, hi_q, lo_q[7:1]};
`ifdef SEQ_MULT8_SKIP_ZERO_EN
    // lo_q[7:1] still holds unconsumed multiplier bits in its low 7-cnt positions
    last_d = (cnt_q == 3'd7) || ((lo_q[7:1] & (7'h7f >> cnt_q)) == 7'd0);
    fin_d  = acc_d >> (3'd7 - cnt_q);
`else
    last_d = (cnt_q == 3'd7);
    fin_d  = acc_d;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_q <= i1;
          hi_q    <= '0;
          lo_q    <= i2;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          {hi_q, lo_q} <= acc_d;
          cnt_q        <= cnt_q + 3'd1;
          if (last_d) begin
            product_q <= fin_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule
